// File: rtl/core_output_buf.sv
// Two-slot result buffer: 8x64-bit words in from the sha512 core, 16x32-bit words out MSW first (err port with OUTBUF_ERR_EN).
// Latency: accepted rd_en -> out_start after START_DLY cycles, data on the following 16 cycles, back-to-back streams contiguous.
// Backpressure: wr_rdy low while both slots are held; rd_en is ignored unless out_ready is high.
module core_output_buf #(
    parameter int SLOTS     = 2,
    parameter int START_DLY = 2
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [63:0] din,
    input  logic        wr_en,
    input  logic        wr_start,
    input  logic        wr_ctx_num,
    input  logic        wr_seq_num,
    output logic        wr_rdy,
    input  logic        rd_en,
    output logic        out_ready,
    output logic        out_ctx_num,
    output logic        out_seq_num,
    output logic        out_start,
    output logic [31:0] dout
`ifdef OUTBUF_ERR_EN
    ,
    output logic        err
`endif
);

    localparam logic [2:0] S_EMPTY = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_FULL  = 3'd2;
    localparam logic [2:0] S_REQ   = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_START  = 2'd2;
    localparam logic [1:0] ST_STREAM = 2'd3;

    localparam logic [3:0] DLY_INIT  = 4'(START_DLY - 1);
    localparam logic [1:0] ACC_STATE = (DLY_INIT == 4'd0) ? ST_START : ST_DELAY;

    logic [2:0]   r_slot_st [SLOTS];
    logic [511:0] r_data    [SLOTS];
    logic         r_ctx     [SLOTS];
    logic         r_seq     [SLOTS];

    logic         r_wr_ptr;
    logic         r_rq_ptr;
    logic         r_rd_ptr;
    logic [2:0]   r_wr_cnt;
    logic [1:0]   r_state;
    logic [3:0]   r_idx;
    logic [3:0]   r_dly;
    logic         r_pend;
    logic [31:0]  r_dout;

    logic         w_wr_fill;
    logic         w_wr_start;
    logic         w_wr_word;
    logic [8:0]   w_wr_base;
    logic         w_out_rdy;
    logic         w_rd_acc;
    logic         w_last;
    logic         w_chain;
    logic         w_nxt_ptr;
    logic [3:0]   w_nxt_idx;
    logic [31:0]  w_nxt_word;

    assign w_wr_fill  = (r_slot_st[r_wr_ptr] == S_FILL);
    assign wr_rdy     = (r_slot_st[r_wr_ptr] == S_EMPTY) || w_wr_fill;
    assign w_wr_start = wr_en && wr_rdy && wr_start;
    assign w_wr_word  = wr_en && w_wr_fill && !wr_start;
    assign w_wr_base  = {r_wr_cnt, 6'd0};

    // r_rq_ptr names the next slot to be requested; r_rd_ptr the slot being streamed
    assign w_out_rdy   = (r_slot_st[r_rq_ptr] == S_FULL) && !r_pend;
    assign w_rd_acc    = rd_en && w_out_rdy;
    assign out_ready   = w_out_rdy;
    assign out_ctx_num = r_ctx[r_rq_ptr];
    assign out_seq_num = r_seq[r_rq_ptr];

    // A queued request whose delay has elapsed starts on the cycle carrying word 0
    assign w_last    = (r_state == ST_STREAM) && (r_idx == 4'd0);
    assign w_chain   = w_last && r_pend && (r_dly == 4'd0);
    assign out_start = (r_state == ST_START) || w_chain;

    assign w_nxt_ptr  = w_last ? ~r_rd_ptr : r_rd_ptr;
    assign w_nxt_idx  = ((r_state == ST_STREAM) && (r_idx != 4'd0)) ? (r_idx - 4'd1) : 4'd15;
    assign w_nxt_word = r_data[w_nxt_ptr][{w_nxt_idx, 5'd0} +: 32];

    assign dout = r_dout;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_slot_st[i] <= S_EMPTY;
                r_data[i]    <= '0;
                r_ctx[i]     <= 1'b0;
                r_seq[i]     <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rq_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_wr_cnt <= 3'd0;
            r_state  <= ST_IDLE;
            r_idx    <= 4'd0;
            r_dly    <= 4'd0;
            r_pend   <= 1'b0;
            r_dout   <= 32'd0;
        end else begin
            if (w_wr_start) begin
                r_data[r_wr_ptr][63:0] <= din;
                r_ctx[r_wr_ptr]        <= wr_ctx_num;
                r_seq[r_wr_ptr]        <= wr_seq_num;
                r_slot_st[r_wr_ptr]    <= S_FILL;
                r_wr_cnt               <= 3'd1;
            end else if (w_wr_word) begin
                r_data[r_wr_ptr][w_wr_base +: 64] <= din;
                if (r_wr_cnt == 3'd7) begin
                    r_slot_st[r_wr_ptr] <= S_FULL;
                    r_wr_ptr            <= ~r_wr_ptr;
                    r_wr_cnt            <= 3'd0;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 3'd1;
                end
            end

            if (w_rd_acc) begin
                r_slot_st[r_rq_ptr] <= S_REQ;
                r_rq_ptr            <= ~r_rq_ptr;
                r_pend              <= 1'b1;
                r_dly               <= DLY_INIT;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_rd_acc) r_state <= ACC_STATE;
                end
                ST_DELAY: begin
                    r_dly <= r_dly - 4'd1;
                    if (r_dly == 4'd1) r_state <= ST_START;
                end
                ST_START: begin
                    r_state             <= ST_STREAM;
                    r_idx               <= 4'd15;
                    r_dout              <= w_nxt_word;
                    r_slot_st[r_rd_ptr] <= S_READ;
                    r_pend              <= 1'b0;
                end
                ST_STREAM: begin
                    if (r_idx != 4'd0) begin
                        r_idx  <= w_nxt_idx;
                        r_dout <= w_nxt_word;
                        if (r_pend && (r_dly != 4'd0)) r_dly <= r_dly - 4'd1;
                    end else begin
                        r_slot_st[r_rd_ptr] <= S_EMPTY;
                        r_rd_ptr            <= ~r_rd_ptr;
                        if (w_chain) begin
                            r_idx                <= 4'd15;
                            r_dout               <= w_nxt_word;
                            r_slot_st[~r_rd_ptr] <= S_READ;
                            r_pend               <= 1'b0;
                        end else if (w_rd_acc) begin
                            r_state <= ACC_STATE;
                        end else if (r_pend) begin
                            r_dly   <= r_dly - 4'd1;
                            r_state <= (r_dly == 4'd1) ? ST_START : ST_DELAY;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef OUTBUF_ERR_EN
    logic r_err;
    logic w_err_ev;

    assign w_err_ev = (wr_en && !wr_rdy)
                   || (wr_en && wr_start && w_wr_fill)
                   || (wr_en && !wr_start && !w_wr_fill)
                   || (rd_en && !w_out_rdy);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_ev) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: doc/core_output_buf.md
Name: core_output_buf

Overview:
- Per-core output buffer between a sha512 core and the memory input manager.
- Accepts one 512-bit result from the core as eight 64-bit words and holds up to two results (double-buffered slots).
- On a read request, streams a held result to the manager as sixteen consecutive 32-bit words, most-significant first.
- Each result carries context and sequence tags that the manager uses to form the thread number.

Parameters:
- SLOTS, 2, number of result slots; fixed at 2, and a 1-bit slot pointer is used.
- START_DLY, 2, cycles from an accepted rd_en to the out_start pulse.

Ports:
- CLK  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- din  input  64  64-bit result word from the core
- wr_en  input  1  din valid
- wr_start  input  1  marks the first word of a result; qualified by wr_en
- wr_ctx_num  input  1  context tag; sampled when wr_en & wr_start
- wr_seq_num  input  1  sequence tag; sampled when wr_en & wr_start
- wr_rdy  output  1  a free slot exists, so the core may begin a new result
- rd_en  input  1  read request pulse from the manager
- out_ready  output  1  a complete, unrequested result is held
- out_ctx_num  output  1  tag of the result out_ready refers to
- out_seq_num  output  1  tag of the result out_ready refers to
- out_start  output  1  one-cycle pulse; first data word follows on the next cycle
- dout  output  32  output data word
- err  output  1  sticky protocol error; present only with OUTBUF_ERR_EN

Behaviour:
- Reset (rst_n low, asynchronous):
  - all slots empty; write and read pointers 0; pending-request flag clear.
  - wr_rdy=1, out_ready=0, out_start=0, dout=0, out_ctx_num=0, out_seq_num=0, err=0.
  - An in-progress write or readout is aborted and its data discarded.
- Write side:
  - The slot at wr_ptr is filled by 8 words, word index 0..7, where word i = result bits [64i+63:64i].
  - The word counter resets on wr_start.
  - After the 8th word the slot is marked full, wr_ptr toggles, and the counter returns to 0.
  - wr_rdy = slot[wr_ptr] empty OR a write is already in progress in that slot.
  - Words written while wr_rdy=0 are ignored.
- Slot states: EMPTY -> FILLING (wr_start) -> FULL (8th word) -> REQUESTED (rd_en accepted) -> READING -> EMPTY (after last word).
- Read side:
  - out_ready = (slot[rd_ptr] FULL) AND (no request pending).
  - out_ctx_num and out_seq_num show that slot's tags.
  - rd_en is accepted only when out_ready=1; otherwise it is ignored.
  - out_ready drops the cycle after an accepted rd_en.
- Readout FSM states: IDLE, DELAY, START, STREAM.
  - rd_en accepted at edge T: DELAY; out_start=1 during cycle T+START_DLY.
  - The data stream then runs cycles T+3 .. T+18 with START_DLY=2.
  - dout stream order is 32-bit word 15 (bits 511:480) first, down to word 0 (bits 31:0) last; one word per cycle with no gaps.
  - At the edge ending the last word, the slot becomes EMPTY, rd_ptr toggles, and the FSM returns to IDLE or serves a pending request.
- Back-to-back requests:
  - rd_en may be accepted during STREAM if the other slot is FULL.
  - Its out_start is asserted at max(T+START_DLY, cycle carrying word 0 of the current stream).
  - Its first word follows immediately, so the output stream stays contiguous.
- dout holds its last value outside STREAM; out_start is never high for 2 consecutive cycles.
- Simultaneous events:
  - A write completing into one slot while the other slot's readout finishes: both take effect in the same cycle.
  - A slot freed in cycle N is writable (wr_rdy=1) in cycle N+1.
- Buffer full: with both slots FULL or REQUESTED, wr_rdy=0 until a readout completes.

Optional Feature:
- Macro: OUTBUF_ERR_EN.
- Defined: err port exists and is set, sticky until reset, on any of:
  - wr_en while wr_rdy=0;
  - wr_start during a partially written slot;
  - wr_en without wr_start while no slot is FILLING;
  - rd_en while out_ready=0.
- The offending input is still ignored exactly as in the base behaviour.
- Undefined: no err port or logic; protocol violations are silently ignored.

Test Plan:
- Single result: write words 0x0..0_i (i=0..7) with ctx=1, seq=0 -> out_ready=1 and out_ctx_num=1; rd_en at T -> out_start at T+2; dout 0x00000000_7's halves, high half first, word15..word0 at T+3..T+18; then out_ready=0, wr_rdy=1.
- Two results A,B written back-to-back -> wr_rdy=0 after B; rd_en for A, then rd_en for B issued at the cycle carrying A's word 2 -> B's out_start coincides with A's word 0; 32 contiguous words.
- Third write attempt while both slots full -> ignored; a later readout of A and B shows no corruption.
- rd_en with out_ready=0 -> no out_start, state unchanged.
- rst_n low mid-stream at word 7 -> outputs return to reset values immediately; after release wr_rdy=1, out_ready=0, no further out_start.
- OUTBUF_ERR_EN: wr_start issued after 3 words of a result -> err=1 and stays 1 until reset.
